// File: rtl/dequeue_agent_v0_1.sv
// dequeue_agent_v0_1: pops PIFO roots and streams the addressed buffer packet.
// Build option: DEQ_STRICT_PRIORITY_EN selects lowest-index-wins arbitration.
module dequeue_agent_v0_1 #(
  parameter int QUEUE_NUM  = 5,
  parameter int ROOT_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic [QUEUE_NUM-1:0]  s_axis_pifo_empty,
  input  logic [ROOT_WIDTH-1:0] s_axis_pifo_root,
  output logic [QUEUE_NUM-1:0]  m_axis_ctl_pifo_out_en,
  input  logic                  s_axis_buffer_tvalid,
  input  logic                  s_axis_buffer_tlast,
  output logic                  m_axis_ctl_buffer_rd_en,
  output logic [ADDR_WIDTH-1:0] m_axis_buffer_rd_addr,
  output logic [QUEUE_NUM-1:0]  m_axis_queue_sel,
  output logic [QUEUE_NUM-1:0]  m_axis_tvalid,
  input  logic [QUEUE_NUM-1:0]  m_axis_tready,
  output logic [15:0]           m_axis_invalid_root_cnt
);

  localparam int PW = (QUEUE_NUM > 1) ? $clog2(QUEUE_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    CAPTURE,
    STREAM
  } state_t;

  state_t state;

  logic [QUEUE_NUM-1:0]  elig;
  logic [QUEUE_NUM-1:0]  grant;
  logic                  grant_any;
  logic [PW-1:0]         grant_idx;
  logic                  root_valid;
  logic [ADDR_WIDTH-1:0] root_addr;
  logic                  in_stream;
  logic                  xfer;
  logic                  unused_root;

`ifndef DEQ_STRICT_PRIORITY_EN
  logic [PW-1:0] rr_ptr;
`endif

  function automatic logic [PW-1:0] wrap_idx(
    input int v
  );
    return PW'(v % QUEUE_NUM);
  endfunction

  assign elig        = ~s_axis_pifo_empty & m_axis_tready;
  assign root_valid  = s_axis_pifo_root[ROOT_WIDTH-1];
  assign root_addr   = s_axis_pifo_root[ADDR_WIDTH-1:0];
  assign unused_root = ^s_axis_pifo_root[ROOT_WIDTH-2:ADDR_WIDTH];

  // Scan from far to near so the nearest eligible index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = |elig;
`ifdef DEQ_STRICT_PRIORITY_EN
    for (int i = QUEUE_NUM - 1; i >= 0; i--) begin
      if (elig[i]) begin
        grant_idx = PW'(i);
      end
    end
`else
    for (int k = QUEUE_NUM; k >= 1; k--) begin
      if (elig[wrap_idx(int'(rr_ptr) + k)]) begin
        grant_idx = wrap_idx(int'(rr_ptr) + k);
      end
    end
`endif
    grant[grant_idx] = grant_any;
  end

  assign in_stream = (state == STREAM);

  assign xfer = in_stream
              & s_axis_buffer_tvalid
              & |(m_axis_queue_sel & m_axis_tready);

  assign m_axis_ctl_buffer_rd_en = xfer;

  assign m_axis_tvalid =
    (in_stream && s_axis_buffer_tvalid) ? m_axis_queue_sel : '0;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state                   <= IDLE;
      m_axis_queue_sel        <= '0;
      m_axis_ctl_pifo_out_en  <= '0;
      m_axis_buffer_rd_addr   <= '0;
      m_axis_invalid_root_cnt <= '0;
`ifndef DEQ_STRICT_PRIORITY_EN
      rr_ptr                  <= PW'(QUEUE_NUM - 1);
`endif
    end else begin
      m_axis_ctl_pifo_out_en <= '0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            m_axis_queue_sel       <= grant;
            m_axis_ctl_pifo_out_en <= grant;
`ifndef DEQ_STRICT_PRIORITY_EN
            rr_ptr                 <= grant_idx;
`endif
            state                  <= POP;
          end
        end
        POP: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (root_valid) begin
            m_axis_buffer_rd_addr <= root_addr;
            state                 <= STREAM;
          end else begin
            if (m_axis_invalid_root_cnt != 16'hFFFF) begin
              m_axis_invalid_root_cnt <=
                m_axis_invalid_root_cnt + 16'd1;
            end
            m_axis_queue_sel <= '0;
            state            <= IDLE;
          end
        end
        STREAM: begin
          if (xfer && s_axis_buffer_tlast) begin
            m_axis_queue_sel <= '0;
            state            <= IDLE;
          end
        end
        default: begin
          m_axis_queue_sel <= '0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dequeue_agent_v0_1.sv
// tb_dequeue_agent_v0_1: PIFO/buffer responder, cycle model and
// directed scenarios for dequeue_agent_v0_1.
module tb_dequeue_agent_v0_1;

  localparam int QN = 5;

  logic          axis_aclk = 1'b0;
  logic          axis_resetn = 1'b1;
  logic [QN-1:0] s_axis_pifo_empty;
  logic [31:0]   s_axis_pifo_root;
  logic [QN-1:0] m_axis_ctl_pifo_out_en;
  logic          s_axis_buffer_tvalid;
  logic          s_axis_buffer_tlast;
  logic          m_axis_ctl_buffer_rd_en;
  logic [11:0]   m_axis_buffer_rd_addr;
  logic [QN-1:0] m_axis_queue_sel;
  logic [QN-1:0] m_axis_tvalid;
  logic [QN-1:0] m_axis_tready;
  logic [15:0]   m_axis_invalid_root_cnt;

  dequeue_agent_v0_1 #(
    .QUEUE_NUM (QN),
    .ROOT_WIDTH(32),
    .ADDR_WIDTH(12)
  ) dut (
    .axis_aclk              (axis_aclk),
    .axis_resetn            (axis_resetn),
    .s_axis_pifo_empty      (s_axis_pifo_empty),
    .s_axis_pifo_root       (s_axis_pifo_root),
    .m_axis_ctl_pifo_out_en (m_axis_ctl_pifo_out_en),
    .s_axis_buffer_tvalid   (s_axis_buffer_tvalid),
    .s_axis_buffer_tlast    (s_axis_buffer_tlast),
    .m_axis_ctl_buffer_rd_en(m_axis_ctl_buffer_rd_en),
    .m_axis_buffer_rd_addr  (m_axis_buffer_rd_addr),
    .m_axis_queue_sel       (m_axis_queue_sel),
    .m_axis_tvalid          (m_axis_tvalid),
    .m_axis_tready          (m_axis_tready),
    .m_axis_invalid_root_cnt(m_axis_invalid_root_cnt)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct {
    int          q;
    logic [31:0] root;
    int          len;
  } pkt_t;

  // responder state
  pkt_t          pend[$];
  logic [31:0]   root_reg;
  bit            buf_on;
  int            cur_len;
  int            cur_idx;
  logic [QN-1:0] rdy;

  // model state
  int            m_srv;
  int            m_age;
  int            m_rr;
  logic [15:0]   m_cnt;
  logic [11:0]   m_addr;

  // observations
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            dut_pops[$];
  int            pop_cycs[$];
  int            rd_cnt;
  int            tv_cnt;
  int            first_tv_cyc;
  logic [QN-1:0] tv_or;

  function automatic logic [QN-1:0] oh(input int q);
    logic [QN-1:0] r;
    r = '0;
    if (q >= 0) r[q] = 1'b1;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_srv  = -1;
    m_age  = 0;
    m_rr   = QN - 1;
    m_cnt  = 16'h0;
    m_addr = 12'h0;
  endtask

  task automatic clr_stats();
    dut_pops.delete();
    pop_cycs.delete();
    rd_cnt       = 0;
    tv_cnt       = 0;
    first_tv_cyc = -1;
    tv_or        = '0;
  endtask

  task automatic drive();
    logic [QN-1:0] e;
    e = '1;
    foreach (pend[i]) e[pend[i].q] = 1'b0;
    s_axis_pifo_empty    = e;
    s_axis_pifo_root     = root_reg;
    s_axis_buffer_tvalid = buf_on;
    s_axis_buffer_tlast  = buf_on && (cur_idx == cur_len - 1);
    m_axis_tready        = rdy;
  endtask

  task automatic enq(input int q, input logic [31:0] root,
                     input int len);
    pkt_t p;
    p.q    = q;
    p.root = root;
    p.len  = len;
    pend.push_back(p);
    drive();
  endtask

  // One clock: compare at the falling edge, advance model and
  // responder, then present the next inputs just after the rise.
  task automatic tick();
    logic [QN-1:0] e_sel, e_pop, e_tv;
    logic          e_rd;
    int            pick;
    int            pq;
    @(negedge axis_aclk);
    e_sel = oh(m_srv);
    e_pop = (m_srv >= 0 && m_age == 1) ? e_sel : '0;
    e_tv  = '0;
    e_rd  = 1'b0;
    if (m_srv >= 0 && m_age >= 3) begin
      e_tv = s_axis_buffer_tvalid ? e_sel : '0;
      e_rd = s_axis_buffer_tvalid && m_axis_tready[m_srv];
    end
    cmp("queue_sel", 32'(m_axis_queue_sel), 32'(e_sel));
    cmp("pifo_out_en", 32'(m_axis_ctl_pifo_out_en), 32'(e_pop));
    cmp("tvalid", 32'(m_axis_tvalid), 32'(e_tv));
    cmp("rd_en", 32'(m_axis_ctl_buffer_rd_en), 32'(e_rd));
    cmp("rd_addr", 32'(m_axis_buffer_rd_addr), 32'(m_addr));
    cmp("invalid_cnt", 32'(m_axis_invalid_root_cnt), 32'(m_cnt));
    // observations of the DUT
    pq = -1;
    for (int i = 0; i < QN; i++)
      if (m_axis_ctl_pifo_out_en[i]) pq = i;
    if (pq >= 0) begin
      dut_pops.push_back(pq);
      pop_cycs.push_back(cyc);
    end
    if (m_axis_ctl_buffer_rd_en) rd_cnt++;
    if (m_axis_tvalid != '0) begin
      tv_cnt++;
      tv_or = tv_or | m_axis_tvalid;
      if (first_tv_cyc < 0) first_tv_cyc = cyc;
    end
    // model advance
    if (!axis_resetn) begin
      model_reset();
    end else if (m_srv < 0) begin
      pick = -1;
      for (int k = 1; k <= QN; k++) begin
        int idx;
`ifdef DEQ_STRICT_PRIORITY_EN
        idx = k - 1;
`else
        idx = (m_rr + k) % QN;
`endif
        if (pick < 0 && !s_axis_pifo_empty[idx] && m_axis_tready[idx])
          pick = idx;
      end
      if (pick >= 0) begin
        m_srv = pick;
        m_age = 1;
        m_rr  = pick;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      if (s_axis_pifo_root[31]) begin
        m_addr = s_axis_pifo_root[11:0];
        m_age  = 3;
      end else begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_srv = -1;
      end
    end else if (e_rd && s_axis_buffer_tlast) begin
      m_srv = -1;
    end
    // responder: PIFO pop and buffer head advance
    if (pq >= 0) begin
      int j;
      j = -1;
      foreach (pend[i]) if (j < 0 && pend[i].q == pq) j = i;
      root_reg = 32'h0;
      if (j >= 0) begin
        root_reg = pend[j].root;
        if (root_reg[31]) begin
          buf_on  = 1'b1;
          cur_len = pend[j].len;
          cur_idx = 0;
        end
        pend.delete(j);
      end
    end
    if (m_axis_ctl_buffer_rd_en && buf_on) begin
      cur_idx++;
      if (cur_idx >= cur_len) buf_on = 1'b0;
    end
    @(posedge axis_aclk);
    #1;
    drive();
    cyc++;
  endtask

  task automatic wait_quiet(input string nm, input int budget);
    int n;
    n = 0;
    while (!(pend.size() == 0 && m_srv < 0) && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, required idle",
               nm, n);
    end
  endtask

  function automatic int pop_at(input int i);
    return (i < dut_pops.size()) ? dut_pops[i] : 99;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int n;
    int tv_before;
    rdy      = '1;
    root_reg = 32'h0;
    buf_on   = 1'b0;
    cur_len  = 0;
    cur_idx  = 0;
    model_reset();
    clr_stats();
    drive();
    #1 axis_resetn = 1'b0;
    #2;
    cmp("rst_sel", 32'(m_axis_queue_sel), 32'h0);
    cmp("rst_pop", 32'(m_axis_ctl_pifo_out_en), 32'h0);
    cmp("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    cmp("rst_rd_en", 32'(m_axis_ctl_buffer_rd_en), 32'h0);
    cmp("rst_addr", 32'(m_axis_buffer_rd_addr), 32'h0);
    cmp("rst_cnt", 32'(m_axis_invalid_root_cnt), 32'h0);
    tick();
    tick();
    axis_resetn = 1'b1;

    // two single-chunk packets each on queues 0 and 2
    clr_stats();
    enq(0, 32'h8000_0010, 1);
    enq(2, 32'h8000_0020, 1);
    enq(0, 32'h8000_0030, 1);
    enq(2, 32'h8000_0040, 1);
    wait_quiet("arb_done", 100);
    cmp("arb_npops", 32'(dut_pops.size()), 32'd4);
`ifdef DEQ_STRICT_PRIORITY_EN
    cmp("arb_grant0", 32'(pop_at(0)), 32'd0);
    cmp("arb_grant1", 32'(pop_at(1)), 32'd0);
    cmp("arb_grant2", 32'(pop_at(2)), 32'd2);
    cmp("arb_grant3", 32'(pop_at(3)), 32'd2);
`else
    cmp("arb_grant0", 32'(pop_at(0)), 32'd0);
    cmp("arb_grant1", 32'(pop_at(1)), 32'd2);
    cmp("arb_grant2", 32'(pop_at(2)), 32'd0);
    cmp("arb_grant3", 32'(pop_at(3)), 32'd2);
`endif
    cmp("arb_rd_pulses", 32'(rd_cnt), 32'd4);
    cmp("arb_pop_spacing",
        32'(pop_cycs.size() >= 2 ? pop_cycs[1] - pop_cycs[0] : 0),
        32'd4);

    // invalid root
    clr_stats();
    enq(1, 32'h0000_0123, 1);
    wait_quiet("inv_done", 50);
    cmp("inv_cnt", 32'(m_axis_invalid_root_cnt), 32'd1);
    cmp("inv_rd_pulses", 32'(rd_cnt), 32'd0);
    cmp("inv_pop_q", 32'(pop_at(0)), 32'd1);
    cmp("inv_sel_idle", 32'(m_axis_queue_sel), 32'h0);

    // four-chunk packet on the CPU port
    clr_stats();
    e0 = cyc;
    enq(4, 32'h8000_0ABC, 4);
    wait_quiet("cpu_done", 50);
    cmp("cpu_addr", 32'(m_axis_buffer_rd_addr), 32'hABC);
    cmp("cpu_rd_pulses", 32'(rd_cnt), 32'd4);
    cmp("cpu_tv_cycles", 32'(tv_cnt), 32'd4);
    cmp("cpu_tv_port", 32'(tv_or), 32'b10000);
    cmp("cpu_pop_lat",
        32'(pop_cycs.size() > 0 ? pop_cycs[0] - e0 : -1), 32'd1);
    cmp("cpu_first_tv", 32'(first_tv_cyc - e0), 32'd3);

    // back-pressure mid-packet on queue 1
    clr_stats();
    enq(1, 32'h8000_0200, 6);
    n = 0;
    while (rd_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    rdy[1] = 1'b0;
    drive();
    tv_before = tv_cnt;
    repeat (5) tick();
    cmp("stall_rd_pulses", 32'(rd_cnt), 32'd2);
    cmp("stall_tv_held", 32'(tv_cnt - tv_before), 32'd5);
    rdy[1] = 1'b1;
    drive();
    wait_quiet("stall_done", 50);
    cmp("stall_total_rd", 32'(rd_cnt), 32'd6);
    cmp("stall_addr", 32'(m_axis_buffer_rd_addr), 32'h200);

    // queue 3 held off by tready
    clr_stats();
    rdy[3] = 1'b0;
    enq(3, 32'h8000_0333, 1);
    repeat (6) tick();
    cmp("hold_no_pop", 32'(dut_pops.size()), 32'd0);
    e0 = cyc;
    rdy[3] = 1'b1;
    drive();
    wait_quiet("hold_done", 50);
    cmp("hold_pop_lat",
        32'(pop_cycs.size() > 0 ? pop_cycs[0] - e0 : -1), 32'd1);
    cmp("hold_pop_q", 32'(pop_at(0)), 32'd3);

    // asynchronous reset during a stream
    clr_stats();
    enq(2, 32'h8000_0222, 8);
    n = 0;
    while (rd_cnt < 1 && n < 50) begin
      tick();
      n++;
    end
    enq(0, 32'h8000_0111, 1);
    enq(4, 32'h8000_0444, 1);
    tick();
    tick();
    #2 axis_resetn = 1'b0;
    #1;
    cmp("arst_sel", 32'(m_axis_queue_sel), 32'h0);
    cmp("arst_pop", 32'(m_axis_ctl_pifo_out_en), 32'h0);
    cmp("arst_tvalid", 32'(m_axis_tvalid), 32'h0);
    cmp("arst_rd_en", 32'(m_axis_ctl_buffer_rd_en), 32'h0);
    cmp("arst_addr", 32'(m_axis_buffer_rd_addr), 32'h0);
    cmp("arst_cnt", 32'(m_axis_invalid_root_cnt), 32'h0);
    buf_on   = 1'b0;
    root_reg = 32'h0;
    model_reset();
    drive();
    clr_stats();
    tick();
    tick();
    axis_resetn = 1'b1;
    wait_quiet("arst_done", 50);
    cmp("arst_npops", 32'(dut_pops.size()), 32'd2);
    cmp("arst_first", 32'(pop_at(0)), 32'd0);
    cmp("arst_second", 32'(pop_at(1)), 32'd4);
    cmp("arst_rd_pulses", 32'(rd_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
